div_unit: RTL and testbench

Multicycle signed 32-bit integer divider for the MIPS datapath; it executes DIV and produces the HI (remainder) and LO (quotient) values. It sits beside the ALU. The control unit drives `start` with the operands from registers A/B and holds in its DIV wait state until `done`. `div_zero` feeds the control unit's divide-by-zero exception input. Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.

---
 rtl/div_unit.sv | 179 +++++++++++++++++
 tb/tb_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multicycle signed radix-2 restoring divider for the MIPS DIV instruction.
// Produces LO (quotient, truncated toward zero) and HI (remainder, dividend's sign).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_ZERO = 3'd4
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   dvsr_q, dvsr_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic             dvsr_zero_s;
    logic [WIDTH:0]   dvd_mag_s;
    logic [WIDTH:0]   dvs_mag_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] quo_sh_s;

    // One extra bit keeps |-2^(WIDTH-1)| exact.
    function automatic logic [WIDTH:0] mag_of(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] e;
        e = {v[WIDTH-1], v};
        if (v[WIDTH-1]) begin
            mag_of = ~e + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mag_of = e;
        end
    endfunction

    function automatic logic [WIDTH-1:0] neg_of(input logic [WIDTH-1:0] v);
        neg_of = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign accept_s    = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ZERO);
    assign dvsr_zero_s = (divisor == {WIDTH{1'b0}});
    assign dvd_mag_s   = mag_of(dividend);
    assign dvs_mag_s   = mag_of(divisor);
    assign rem_sh_s    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign quo_sh_s    = {quo_q[WIDTH-2:0], 1'b0};

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {(WIDTH+1){1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            dvsr_q  <= {(WIDTH+1){1'b0}};
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ZERO: begin
                if (accept_s) begin
                    state_d = dvsr_zero_s ? S_ZERO : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dz_d   = dz_q;
        case (state_q)
            S_IDLE, S_DONE, S_ZERO: begin
                if (accept_s) begin
                    cnt_d  = CNT_INIT;
                    rem_d  = {(WIDTH+1){1'b0}};
                    quo_d  = dvd_mag_s[WIDTH-1:0];
                    dvsr_d = dvs_mag_s;
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
                    dz_d   = dvsr_zero_s;
                end else begin
                    dz_d   = dz_q;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (rem_sh_s >= dvsr_q) begin
                    rem_d = rem_sh_s - dvsr_q;
                    quo_d = quo_sh_s | {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    rem_d = rem_sh_s;
                    quo_d = quo_sh_s;
                end
            end
            S_FIX: begin
                lo_d = qneg_q ? neg_of(quo_q) : quo_q;
                hi_d = rneg_q ? neg_of(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE) || (state_d == S_ZERO);
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a driver issues divisions and queues the
// expected result and arrival cycle; a negedge monitor pops and compares.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ncyc  = 0;

    logic [W-1:0] q_lo[$];
    logic [W-1:0] q_hi[$];
    logic         q_dz[$];
    int           q_cyc[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, so INT_MIN / -1 does not overflow.
    task automatic expect_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) begin
            q_lo.push_back(model_lo);
            q_hi.push_back(model_hi);
            q_dz.push_back(1'b1);
            q_cyc.push_back(ncyc + 1);
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            model_lo = q[W-1:0];
            model_hi = r[W-1:0];
            q_lo.push_back(model_lo);
            q_hi.push_back(model_hi);
            q_dz.push_back(1'b0);
            q_cyc.push_back(ncyc + W + 2);
        end
    endtask

    // Monitor: compares every done pulse against the head of the scoreboard.
    always @(negedge clk) begin
        ncyc++;
        if (busy && done) begin
            tests++;
            fails++;
            $display("FAIL busy_done_overlap: busy=%b done=%b at cycle %0d", busy, done, ncyc);
        end
        if (done) begin
            if (q_lo.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", ncyc);
            end else begin
                check("lo", lo, q_lo.pop_front());
                check("hi", hi, q_hi.pop_front());
                check("div_zero", div_zero, q_dz.pop_front());
                check("done_cycle", ncyc, q_cyc.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
        if (!now) begin
            @(negedge clk);
            #1;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        expect_div(a, b);
        @(negedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", busy, (b != '0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            @(negedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL timeout: got no done expected done within 60 cycles");
        q_lo.delete(); q_hi.delete(); q_dz.delete(); q_cyc.delete();
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b, 1'b0);
        wait_done();
    endtask

    initial begin
        logic [W-1:0] a, b;
        int mode;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", div_zero, 1'b0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        reset = 1'b1;

        run_div(32'd7, 32'd2);
        run_div(32'hFFFFFFF9, 32'd2);
        run_div(32'd7, 32'hFFFFFFFE);
        run_div(32'hFFFFFFF9, 32'hFFFFFFFE);
        run_div(32'd100, 32'd7);
        run_div(32'd5, 32'd0);
        @(negedge clk);
        #1;
        check("zero_busy", busy, 1'b0);
        check("zero_dz_hold", div_zero, 1'b1);
        run_div(32'h80000000, 32'hFFFFFFFF);
        check("dz_cleared", div_zero, 1'b0);
        run_div(32'd0, 32'd9);
        run_div(32'd3, 32'd9);

        // start during a run with different operands must be ignored
        issue(32'd1000, 32'd33, 1'b0);
        repeat (9) @(negedge clk);
        #1;
        dividend = 32'd55;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done();

        // back-to-back: new start in the DONE cycle, then in a ZERO cycle
        run_div(32'd100, 32'd7);
        issue(32'hFFFFFFCE, 32'd3, 1'b1);
        wait_done();
        issue(32'd9, 32'd0, 1'b1);
        wait_done();
        issue(32'd77, 32'd5, 1'b1);
        wait_done();

        // reset in the middle of a division
        issue(32'd12345, 32'd67, 1'b0);
        repeat (13) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_dz", div_zero, 1'b0);
        q_lo.delete(); q_hi.delete(); q_dz.delete(); q_cyc.delete();
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 4);
            a = $urandom;
            b = $urandom;
            case (mode)
                0: b = '0;
                1: begin
                    a = $urandom_range(0, 200) - 100;
                    b = $urandom_range(0, 20) - 10;
                end
                3: begin
                    a = (i % 3 == 0) ? 32'h80000000 : ((i % 3 == 1) ? 32'h7FFFFFFF : 32'hFFFFFFFF);
                    b = (i % 2 == 0) ? 32'hFFFFFFFF : 32'd1;
                end
                4: b = $urandom_range(1, 1000);
                default: ;
            endcase
            issue(a, b, (done && (i % 2 == 1)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        tests++;
        if (q_lo.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_lo.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
